// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// One bit per cycle on operand magnitudes; signs are restored in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state, w_state_nxt;
  op_t                r_op;
  logic               r_sa, r_sb;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_accept, w_commit, w_mt_ok;
  logic               w_in_signed, w_is_div;
  logic [WIDTH-1:0]   w_rs_mag, w_rt_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_hi_res, w_lo_res;

  // Mul: add multiplicand a into the upper half when b[0] is set, then shift right.
  // Div: shift in the next dividend bit a[MSB] and try to subtract divisor b.
  function automatic logic [2*WIDTH-1:0] f_step(input logic             is_div,
                                                input logic [2*WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0]   a,
                                                input logic [WIDTH-1:0]   b);
    logic [WIDTH:0] sum, rem_sh, diff;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b[0] ? {1'b0, a} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], a[WIDTH-1]};
    diff   = rem_sh - {1'b0, b};
    if (!is_div)
      f_step = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      f_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      f_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  assign w_in_signed = (op_t'(op) == OP_MULT) || (op_t'(op) == OP_DIV);
  assign w_rs_mag    = (w_in_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign w_rt_mag    = (w_in_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
        CALC: if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = FIX;
        FIX: begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_mt_ok = (r_state == IDLE) && !abort;

  // Signs are only recorded for signed ops, so unsigned results pass straight through.
  // With a zero divisor the remainder path shifts the dividend magnitude through unchanged.
  always_comb begin
    w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_hi_res = w_prod[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (w_is_div) begin
      w_hi_res = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      if (r_b == '0)
        w_lo_res = '1;
      else
        w_lo_res = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_MULT;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op_t'(op);
        r_sa  <= w_in_signed && rs_val[WIDTH-1];
        r_sb  <= w_in_signed && rt_val[WIDTH-1];
        r_a   <= w_rs_mag;
        r_b   <= w_rt_mag;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == CALC && !abort) begin
        r_acc <= f_step(w_is_div, r_acc, r_a, r_b);
        r_cnt <= r_cnt + 1'b1;
        if (w_is_div) r_a <= r_a << 1;
        else          r_b <= r_b >> 1;
      end
      if (abort || w_commit) r_cnt <= '0;
      if (w_mt_ok && hi_we) r_hi <= wdata;
      if (w_mt_ok && lo_we) r_lo <= wdata;
      if (w_commit) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
      r_done <= w_commit;
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule
